cache_refill_ctrl: RTL and testbench

Miss-handling controller placed directly upstream of the direct-mapped cache. It accepts a processor read request, drives the cache lookup address, and on a miss fetches the aligned 4-word block from main memory one word at a time. It then presents the block on the cache's four-port fill interface for a single cWrite cycle. After the fill it re-runs the lookup, so every completed request ends on a hit.

---
 rtl/cache_refill_ctrl.sv | 132 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller in front of a direct-mapped cache: lookup, 4-word block refill, re-lookup.
// Latency: hit -> ready 1 cycle after req; miss -> 3 + memory wait cycles (min 7).
// Backpressure: memory stalls via memReady hold FETCH; req is only sampled in IDLE.
// Optional miss counter: define CACHE_REFILL_MISSCNT_EN to implement `misses`, else it is tied to 0.
module cache_refill_ctrl #(
  parameter int WORD  = 32,
  parameter int ADDRL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [ADDRL-1:0] reqAddr,
  output logic             ready,
  output logic [ADDRL-1:0] address,
  output logic             cRead,
  input  logic             hit,
  output logic             cWrite,
  output logic [ADDRL-1:0] adr0,
  output logic [ADDRL-1:0] adr1,
  output logic [ADDRL-1:0] adr2,
  output logic [ADDRL-1:0] adr3,
  output logic [WORD-1:0]  block0,
  output logic [WORD-1:0]  block1,
  output logic [WORD-1:0]  block2,
  output logic [WORD-1:0]  block3,
  output logic             memRead,
  output logic [ADDRL-1:0] memAddr,
  input  logic [WORD-1:0]  memData,
  input  logic             memReady,
  output logic [14:0]      misses
);

  typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, FILL} state_t;

  state_t           state, state_nxt;
  logic [ADDRL-1:0] addr;
  logic [1:0]       cnt;
  logic [WORD-1:0]  blk [4];
  logic             word_done;
  logic             miss_evt;

  // A word is only accepted while actually fetching; stray memReady elsewhere is ignored.
  assign word_done = (state == FETCH) && memReady;
  assign miss_evt  = (state == LOOKUP) && !hit;

  assign address = addr;
  assign memAddr = {addr[ADDRL-1:2], cnt};
  assign block0  = blk[0];
  assign block1  = blk[1];
  assign block2  = blk[2];
  assign block3  = blk[3];

  // State register; async reset also drops memRead immediately since outputs decode state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    cRead     = 1'b0;
    cWrite    = 1'b0;
    memRead   = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        cRead = 1'b1;
        if (hit) begin
          ready     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        memRead = 1'b1;
        if (memReady && (cnt == 2'd3)) state_nxt = FILL;
      end
      FILL: begin
        cWrite    = 1'b1;
        state_nxt = LOOKUP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, word counter, block capture and fill addresses (held outside FILL).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      cnt  <= '0;
      adr0 <= '0;
      adr1 <= '0;
      adr2 <= '0;
      adr3 <= '0;
      for (int i = 0; i < 4; i++) blk[i] <= '0;
    end else begin
      if ((state == IDLE) && req) addr <= reqAddr;
      if (miss_evt) cnt <= 2'd0;
      if (word_done) begin
        blk[cnt] <= memData;
        cnt      <= cnt + 2'd1;
        // Fill addresses are set up alongside the last word so they are stable during FILL.
        if (cnt == 2'd3) begin
          adr0 <= {addr[ADDRL-1:2], 2'd0};
          adr1 <= {addr[ADDRL-1:2], 2'd1};
          adr2 <= {addr[ADDRL-1:2], 2'd2};
          adr3 <= {addr[ADDRL-1:2], 2'd3};
        end
      end
    end
  end

`ifdef CACHE_REFILL_MISSCNT_EN
  logic [14:0] miss_q;

  // Miss counter, wraps naturally at 15 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          miss_q <= '0;
    else if (miss_evt) miss_q <= miss_q + 15'd1;
  end

  assign misses = miss_q;
`else
  assign misses = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural tag-store standing in for the cache.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [14:0] reqAddr;
  logic        ready;
  logic [14:0] address;
  logic        cRead;
  logic        hit;
  logic        cWrite;
  logic [14:0] adr0, adr1, adr2, adr3;
  logic [31:0] block0, block1, block2, block3;
  logic        memRead;
  logic [14:0] memAddr;
  logic [31:0] memData;
  logic        memReady;
  logic [14:0] misses;

  int checks = 0;
  int errors = 0;

  cache_refill_ctrl #(.WORD(32), .ADDRL(15)) dut (
    .clk(clk), .rst(rst), .req(req), .reqAddr(reqAddr), .ready(ready),
    .address(address), .cRead(cRead), .hit(hit), .cWrite(cWrite),
    .adr0(adr0), .adr1(adr1), .adr2(adr2), .adr3(adr3),
    .block0(block0), .block1(block1), .block2(block2), .block3(block3),
    .memRead(memRead), .memAddr(memAddr), .memData(memData), .memReady(memReady),
    .misses(misses)
  );

  always #5 clk = ~clk;

  // Cache tag store: 4096 lines, 3-bit tag, filled on cWrite.
  logic       cv [4096];
  logic [2:0] ct [4096];

  assign hit = cRead && cv[address[11:0]] && (ct[address[11:0]] == address[14:12]);

  always @(posedge clk) begin
    if (cWrite) begin
      cv[adr0[11:0]] <= 1'b1; ct[adr0[11:0]] <= adr0[14:12];
      cv[adr1[11:0]] <= 1'b1; ct[adr1[11:0]] <= adr1[14:12];
      cv[adr2[11:0]] <= 1'b1; ct[adr2[11:0]] <= adr2[14:12];
      cv[adr3[11:0]] <= 1'b1; ct[adr3[11:0]] <= adr3[14:12];
    end
  end

  // Observations from the last request.
  int          rdy_cyc;
  int          nfetch;
  int          ncw;
  int          overlap;
  logic [14:0] faddr [16];
  logic [14:0] cw_adr [4];
  logic [31:0] cw_blk [4];

  function automatic logic [14:0] exp_miss(input int n);
`ifdef CACHE_REFILL_MISSCNT_EN
    return n[14:0];
`else
    return 15'd0;
`endif
  endfunction

  // Issue one request; memory answers word w with base+w, memReady on every period-th fetch cycle.
  task automatic do_req(input logic [14:0] a, input logic [31:0] base, input int period);
    int fidx;
    rdy_cyc = -1; nfetch = 0; ncw = 0; overlap = 0; fidx = 0;
    @(negedge clk);
    req = 1'b1; reqAddr = a;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      req = 1'b0;
      if (ready && cWrite) overlap++;
      if (cWrite) begin
        ncw++;
        cw_adr[0] = adr0; cw_adr[1] = adr1; cw_adr[2] = adr2; cw_adr[3] = adr3;
        cw_blk[0] = block0; cw_blk[1] = block1; cw_blk[2] = block2; cw_blk[3] = block3;
      end
      if (memRead) begin
        memData  = base + {30'd0, memAddr[1:0]};
        memReady = ((fidx % period) == period - 1);
        if (memReady && nfetch < 16) begin
          faddr[nfetch] = memAddr;
          nfetch++;
        end
        fidx++;
      end else begin
        memReady = (period == 1);
        memData  = 32'hDEAD_BEEF;
      end
      if (ready) begin
        rdy_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic any;
    any = 1'b0;
    rst = 1'b0; req = 1'b0; reqAddr = '0; memReady = 1'b0; memData = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready || cRead || cWrite || memRead || (address != 0) || (memAddr != 0) ||
          (adr0 | adr1 | adr2 | adr3) != 0 || (block0 | block1 | block2 | block3) != 0 ||
          (misses != 0))
        any = 1'b1;
    end
    checks++;
    if (any !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: some output nonzero (misses=%0h memRead=%0b cWrite=%0b), required all 0",
               misses, memRead, cWrite);
    end
  endtask

  task automatic test_cold_miss;
    do_req(15'h1005, 32'hA0, 1);
    checks++;
    if (rdy_cyc !== 7) begin errors++; $display("FAIL cold_latency: got %0d required 7", rdy_cyc); end
    checks++;
    if (nfetch !== 4) begin errors++; $display("FAIL cold_nfetch: got %0d required 4", nfetch); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (faddr[i] !== 15'h1004 + 15'(i)) begin
        errors++; $display("FAIL cold_memaddr%0d: got %h required %h", i, faddr[i], 15'h1004 + 15'(i));
      end
    end
    checks++;
    if (ncw !== 1) begin errors++; $display("FAIL cold_cwrite_count: got %0d required 1", ncw); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cw_adr[i] !== 15'h1004 + 15'(i) || cw_blk[i] !== 32'hA0 + i) begin
        errors++;
        $display("FAIL cold_fill%0d: adr %h blk %h required adr %h blk %h",
                 i, cw_adr[i], cw_blk[i], 15'h1004 + 15'(i), 32'hA0 + i);
      end
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL cold_overlap: ready&cWrite %0d times required 0", overlap); end
    checks++;
    if (misses !== exp_miss(1)) begin errors++; $display("FAIL cold_misses: got %0d required %0d", misses, exp_miss(1)); end
  endtask

  task automatic test_hit;
    do_req(15'h1006, 32'hEE, 1);
    checks++;
    if (rdy_cyc !== 1) begin errors++; $display("FAIL hit_latency: got %0d required 1", rdy_cyc); end
    checks++;
    if (nfetch !== 0 || ncw !== 0) begin
      errors++; $display("FAIL hit_no_fetch: fetches %0d cwrites %0d required 0 0", nfetch, ncw);
    end
    checks++;
    if (misses !== exp_miss(1)) begin errors++; $display("FAIL hit_misses: got %0d required %0d", misses, exp_miss(1)); end
  endtask

  task automatic test_stall;
    do_req(15'h2109, 32'hB0, 3);
    checks++;
    if (rdy_cyc !== 15) begin errors++; $display("FAIL stall_latency: got %0d required 15", rdy_cyc); end
    checks++;
    if (nfetch !== 4) begin errors++; $display("FAIL stall_nfetch: got %0d required 4", nfetch); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (faddr[i] !== 15'h2108 + 15'(i) || cw_blk[i] !== 32'hB0 + i) begin
        errors++;
        $display("FAIL stall_word%0d: addr %h blk %h required addr %h blk %h",
                 i, faddr[i], cw_blk[i], 15'h2108 + 15'(i), 32'hB0 + i);
      end
    end
    checks++;
    if (misses !== exp_miss(2)) begin errors++; $display("FAIL stall_misses: got %0d required %0d", misses, exp_miss(2)); end
  endtask

  task automatic test_reset_mid_fetch;
    int got;
    int cw_seen;
    got = 0; cw_seen = 0;
    @(negedge clk);
    req = 1'b1; reqAddr = 15'h3012;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      @(negedge clk);
      req = 1'b0;
      memReady = 1'b1;
      memData  = 32'hC0 + {30'd0, memAddr[1:0]};
      if (memRead) got++;
    end
    // Two words accepted at the next edge; reset lands while the third is pending.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (memRead !== 1'b0 || cWrite !== 1'b0 || block0 !== 32'd0) begin
      errors++;
      $display("FAIL midfetch_reset: memRead %0b cWrite %0b block0 %h required 0 0 0", memRead, cWrite, block0);
    end
    repeat (2) begin
      @(negedge clk);
      if (cWrite) cw_seen++;
    end
    rst = 1'b1;
    memReady = 1'b0;
    checks++;
    if (cw_seen !== 0 || misses !== 15'd0) begin
      errors++; $display("FAIL midfetch_after: cWrite %0d misses %0d required 0 0", cw_seen, misses);
    end
    do_req(15'h3012, 32'hD0, 1);
    checks++;
    if (rdy_cyc !== 7 || nfetch !== 4 || ncw !== 1) begin
      errors++;
      $display("FAIL refetch: ready %0d fetches %0d cwrites %0d required 7 4 1", rdy_cyc, nfetch, ncw);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (faddr[i] !== 15'h3010 + 15'(i) || cw_blk[i] !== 32'hD0 + i) begin
        errors++;
        $display("FAIL refetch_word%0d: addr %h blk %h required addr %h blk %h",
                 i, faddr[i], cw_blk[i], 15'h3010 + 15'(i), 32'hD0 + i);
      end
    end
    checks++;
    if (misses !== exp_miss(1)) begin errors++; $display("FAIL refetch_misses: got %0d required %0d", misses, exp_miss(1)); end
  endtask

  task automatic test_back_to_back;
    do_req(15'h1004, 32'hEE, 1);
    checks++;
    if (rdy_cyc !== 1) begin errors++; $display("FAIL b2b_first: got %0d required 1", rdy_cyc); end
    do_req(15'h1007, 32'hEE, 1);
    checks++;
    if (rdy_cyc !== 1 || nfetch !== 0) begin
      errors++; $display("FAIL b2b_second: ready %0d fetches %0d required 1 0", rdy_cyc, nfetch);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin cv[i] = 1'b0; ct[i] = 3'd0; end
    test_reset;
    test_cold_miss;
    test_hit;
    test_stall;
    test_reset_mid_fetch;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
